// File: rtl/intra_tap_combiner_pkg.sv
// Shared constants and beat type for the angular-predictor tap combiner.
package intra_tap_combiner_pkg;

  localparam int PIX_W     = 8;
  localparam int PROD_W    = 16;
  localparam int SHIFT     = 6;
  localparam int ROUND_OFS = 1 << (SHIFT - 1);
  localparam int PIX_MAX   = 255;

  typedef struct packed {
    logic signed [PROD_W-1:0] p0;
    logic signed [PROD_W-1:0] p1;
    logic signed [PROD_W-1:0] p2;
    logic signed [PROD_W-1:0] p3;
    logic                     bypass;
    logic [PIX_W-1:0]         ref_pix;
  } tap_beat_t;

endpackage

// File: rtl/intra_tap_combiner_round_clip_u8.sv
// Rounds a signed filter sum by 2^SHIFT_N (floor after bias) and clips it to 0..255.
module round_clip_u8 #(
  parameter int SUM_W   = 18,
  parameter int SHIFT_N = 6
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic [7:0]              pix
);
  import intra_tap_combiner_pkg::*;

  // One extra bit so the rounding bias cannot wrap at the positive extreme.
  localparam int EXT_W = SUM_W + 1;

  logic signed [EXT_W-1:0] biased_s;
  logic signed [EXT_W-1:0] shifted_s;

  // Bias, arithmetic shift, then saturate to pixel range.
  always_comb begin
    biased_s  = EXT_W'(sum) + EXT_W'(1 << (SHIFT_N - 1));
    shifted_s = biased_s >>> SHIFT_N;
    if (shifted_s[EXT_W-1]) begin
      pix = 8'd0;
    end else if (shifted_s > EXT_W'(PIX_MAX)) begin
      pix = 8'(PIX_MAX);
    end else begin
      pix = shifted_s[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/intra_tap_combiner.sv
// Two-stage valid/ready combiner: sums four tap products, rounds and clips to a
// pixel (or bypasses the integer reference), and flags the last sample of a row.
module intra_tap_combiner #(
  parameter int N_SAMPLES = 16,
  parameter int PROD_W    = intra_tap_combiner_pkg::PROD_W,
  parameter int SHIFT     = intra_tap_combiner_pkg::SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_p0,
  input  logic signed [PROD_W-1:0] in_p1,
  input  logic signed [PROD_W-1:0] in_p2,
  input  logic signed [PROD_W-1:0] in_p3,
  input  logic                     in_bypass,
  input  logic [7:0]               in_ref,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_pix,
  output logic                     out_last
);
  import intra_tap_combiner_pkg::*;

  localparam int PAIR_W = PROD_W + 1;
  localparam int SUM_W  = PROD_W + 2;
  localparam int CNT_W  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  logic                     s1_valid_r;
  logic signed [PAIR_W-1:0] s1_sa_r;
  logic signed [PAIR_W-1:0] s1_sb_r;
  logic                     s1_bypass_r;
  logic [PIX_W-1:0]         s1_ref_r;

  logic                     s2_valid_r;
  logic [PIX_W-1:0]         s2_pix_r;
  logic [CNT_W-1:0]         cnt_r;

  logic                     s2_load_s;
  logic                     accept_s;
  logic                     out_fire_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic [PIX_W-1:0]         filt_pix_s;

  // Handshake decode; clear blocks intake so the beat presented with it is not taken.
  always_comb begin
    s2_load_s  = ~s2_valid_r | out_ready;
    in_ready   = ~clear & (~s1_valid_r | s2_load_s);
    accept_s   = in_valid & in_ready;
    out_fire_s = s2_valid_r & out_ready;
    sum_s      = SUM_W'(s1_sa_r) + SUM_W'(s1_sb_r);
  end

  round_clip_u8 #(
    .SUM_W   (SUM_W),
    .SHIFT_N (SHIFT)
  ) u_round_clip (
    .sum (sum_s),
    .pix (filt_pix_s)
  );

  // Stage 1: pairwise tap sums plus bypass side-band.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sa_r     <= '0;
      s1_sb_r     <= '0;
      s1_bypass_r <= 1'b0;
      s1_ref_r    <= '0;
    end else if (clear) begin
      s1_valid_r  <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      s1_sa_r     <= PAIR_W'(in_p0) + PAIR_W'(in_p1);
      s1_sb_r     <= PAIR_W'(in_p2) + PAIR_W'(in_p3);
      s1_bypass_r <= in_bypass;
      s1_ref_r    <= in_ref;
    end else if (s2_load_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Stage 2: final pixel is registered so outputs hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_pix_r   <= '0;
    end else if (clear) begin
      s2_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_pix_r <= s1_bypass_r ? s1_ref_r : filt_pix_s;
      end
    end
  end

  // Row position counter, advanced once per output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (out_fire_s) begin
      cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_r;
  assign out_pix   = s2_pix_r;
  assign out_last  = s2_valid_r & (cnt_r == CNT_LAST);

endmodule

// File: tb/tb_intra_tap_combiner.sv
// Directed self-checking bench for intra_tap_combiner.
module tb_intra_tap_combiner;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_p0 = 16'sd0;
  logic signed [15:0] in_p1 = 16'sd0;
  logic signed [15:0] in_p2 = 16'sd0;
  logic signed [15:0] in_p3 = 16'sd0;
  logic               in_bypass = 1'b0;
  logic [7:0]         in_ref = 8'd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_pix;
  logic               out_last;

  int errors = 0;
  int checks = 0;

  intra_tap_combiner #(.N_SAMPLES(16), .PROD_W(16), .SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p0(in_p0), .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
    .in_bypass(in_bypass), .in_ref(in_ref),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat k: taps sum to 64k+20, which rounds to pixel k.
  task automatic set_beat(input int k);
    in_p0 = 16'(k * 16);
    in_p1 = 16'(k * 16);
    in_p2 = 16'(k * 16);
    in_p3 = 16'(k * 16 + 20);
    in_bypass = 1'b0;
    in_ref = 8'd0;
  endtask

  task automatic send_one(input int a, input int b, input int c, input int d,
                          input logic byp, input logic [7:0] rf);
    in_p0 = 16'(a); in_p1 = 16'(b); in_p2 = 16'(c); in_p3 = 16'(d);
    in_bypass = byp; in_ref = rf;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_pix !== 8'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b pix=%0d last=%b, want 0 0 0", out_valid, out_pix, out_last);
    end
    step();
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_p0 = -16'sd200; in_p1 = 16'sd5300; in_p2 = 16'sd1600; in_p3 = -16'sd300;
    in_bypass = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency1: out_valid=%b want 0 after one cycle", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd100) begin
      errors++;
      $display("FAIL single_pix: valid=%b pix=%0d want 1 100", out_valid, out_pix);
    end
    step();
  endtask

  task automatic test_rounding();
    int sums [4] = '{31, 32, 95, 96};
    int exps [4] = '{0, 1, 1, 2};
    for (int i = 0; i < 4; i++) begin
      send_one(sums[i] - 10, 10, 0, 0, 1'b0, 8'd0);
      checks++;
      if (out_valid !== 1'b1 || out_pix !== 8'(exps[i])) begin
        errors++;
        $display("FAIL round_sum%0d: valid=%b pix=%0d want 1 %0d", sums[i], out_valid, out_pix, exps[i]);
      end
    end
  endtask

  task automatic test_clip();
    send_one(-765, 0, 0, 0, 1'b0, 8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd0) begin
      errors++;
      $display("FAIL clip_low: valid=%b pix=%0d want 1 0", out_valid, out_pix);
    end
    send_one(20000, 0, 0, 0, 1'b0, 8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd255) begin
      errors++;
      $display("FAIL clip_high: valid=%b pix=%0d want 1 255", out_valid, out_pix);
    end
    send_one(20000, 20000, -3000, 7, 1'b1, 8'd77);
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd77) begin
      errors++;
      $display("FAIL bypass: valid=%b pix=%0d want 1 77", out_valid, out_pix);
    end
    send_one(32767, 32767, 32767, 32767, 1'b0, 8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd255) begin
      errors++;
      $display("FAIL clip_max_taps: valid=%b pix=%0d want 1 255", out_valid, out_pix);
    end
    send_one(-32768, -32768, -32768, -32768, 1'b0, 8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_pix !== 8'd0) begin
      errors++;
      $display("FAIL clip_min_taps: valid=%b pix=%0d want 1 0", out_valid, out_pix);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int first = -1;
    int lastc = -1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 17; c++) begin
      in_valid = (sent < 17);
      set_beat(sent);
      #1;
      if (out_valid) begin
        checks++;
        if (out_pix !== 8'(got) || out_last !== (got == 15)) begin
          errors++;
          $display("FAIL b2b_out%0d: pix=%0d last=%b want %0d %b", got, out_pix, out_last, got, got == 15);
        end
        if (first < 0) first = c;
        lastc = c;
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 17 || lastc - first != 16) begin
      errors++;
      $display("FAIL b2b_throughput: outputs=%0d span=%0d want 17 16", got, lastc - first);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int got = 0;
    int stall_acc = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      out_ready = (c >= 5);
      in_valid = (sent < 6);
      set_beat(100 + sent);
      #1;
      if (c == 4) begin
        checks++;
        if (stall_acc != 2 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: accepts=%0d in_ready=%b want 2 0", stall_acc, in_ready);
        end
      end
      if (c < 5 && out_valid) begin
        checks++;
        if (out_pix !== 8'd100) begin
          errors++;
          $display("FAIL stall_hold: pix=%0d want 100", out_pix);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_pix !== 8'(100 + got)) begin
          errors++;
          $display("FAIL stall_order%0d: pix=%0d want %0d", got, out_pix, 100 + got);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sent++;
        if (c < 5) stall_acc++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6 || sent != 6) begin
      errors++;
      $display("FAIL stall_count: sent=%0d got=%0d want 6 6", sent, got);
    end
  endtask

  task automatic test_clear();
    int sent = 0;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 7; c++) begin
      in_valid = 1'b1;
      set_beat(200 + sent);
      #1;
      if (out_valid) got++;
      if (in_ready) sent++;
      step();
    end
    clear = 1'b1;
    in_valid = 1'b1;
    set_beat(250);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: in_ready=%b want 0", in_ready);
    end
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: out_valid=%b want 0", out_valid);
    end
    sent = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      in_valid = (sent < 16);
      set_beat(sent);
      #1;
      if (out_valid) begin
        checks++;
        if (out_pix !== 8'(got) || out_last !== (got == 15)) begin
          errors++;
          $display("FAIL clear_row%0d: pix=%0d last=%b want %0d %b", got, out_pix, out_last, got, got == 15);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL clear_count: got=%0d want 16", got);
    end
  endtask

  task automatic test_reset_midrow();
    int sent = 0;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      in_valid = 1'b1;
      set_beat(50 + sent);
      #1;
      if (out_valid) got++;
      if (in_ready) sent++;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_pix !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b last=%b pix=%0d want 0 0 0", out_valid, out_last, out_pix);
    end
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    sent = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      in_valid = (sent < 16);
      set_beat(30 + sent);
      #1;
      if (out_valid) begin
        checks++;
        if (out_pix !== 8'(30 + got) || out_last !== (got == 15)) begin
          errors++;
          $display("FAIL rst_row%0d: pix=%0d last=%b want %0d %b", got, out_pix, out_last, 30 + got, got == 15);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL rst_count: got=%0d want 16", got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_clip();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_midrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
